// File: rtl/i2s_frame_capture.sv
// rtl/i2s_frame_capture.sv - I2S ADC capture into ping-pong frame banks, committed as RAM write bursts
// Optional feature macro: FRAME_CAP_MONO_EN (downmix each L/R pair to mono before banking).
// Ports:
//   clk, rst_n             system clock; asynchronous active-low reset
//   bclk, adclrck, adcdat  codec I2S inputs, asynchronous, 2-flop synchronised (adclrck 0 = left)
//   enable                 capture runs while high; low discards the partial frame
//   target                 RAM select (0 = Rx, 1 = Tx), latched at burst launch
//   req_ready, busy        status from the RAM read/write controller
//   req_valid              write request / burst active
//   req_type, stop         constant 1 (write) and constant 0
//   req_target             latched target
//   data_l, data_r         burst write data (word i present while address i is written)
//   frame_done             one-cycle pulse when a frame commit completes
//   overrun                sticky frame-drop flag, cleared by reset or a rising edge of enable
module i2s_frame_capture #(
  parameter int FRAME_LEN = 256,
  parameter int AW        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bclk,
  input  logic        adclrck,
  input  logic        adcdat,
  input  logic        enable,
  input  logic        target,
  input  logic        req_ready,
  input  logic        busy,
  output logic        req_valid,
  output logic        req_type,
  output logic        req_target,
  output logic        stop,
  output logic [15:0] data_l,
  output logic [15:0] data_r,
  output logic        frame_done,
  output logic        overrun
);

  localparam int             DEPTH    = 2 ** (AW + 1);
  localparam logic [AW-1:0]  LAST_IDX = AW'(FRAME_LEN - 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FRAME_LEN);

  assign req_type = 1'b1;
  assign stop     = 1'b0;

  // ---------------- input synchronisers ----------------
  logic [1:0] bclk_sync, lrck_sync, dat_sync;
  logic       bclk_d;
  logic       bclk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b00;
      dat_sync  <= 2'b00;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrck_sync <= {lrck_sync[0], adclrck};
      dat_sync  <= {dat_sync[0], adcdat};
      bclk_d    <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_d;

  // ---------------- deserialiser ----------------
  // bit_cnt is cleared on the BCLK rise that sees the LRCK change; the
  // following 16 rises carry MSB..LSB. A value of 16 means "slot finished".
  logic        lrck_prev;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [15:0] left_hold;
  logic        left_valid;
  logic        pair_valid;
  logic [15:0] pair_l, pair_r;
  logic [15:0] word_next;

  assign word_next = {shreg[14:0], dat_sync[1]};

`ifdef FRAME_CAP_MONO_EN
  logic [16:0] mix_sum;
  assign mix_sum = {left_hold[15], left_hold} + {word_next[15], word_next};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_prev  <= 1'b0;
      bit_cnt    <= 5'd16;
      shreg      <= '0;
      left_hold  <= '0;
      left_valid <= 1'b0;
      pair_valid <= 1'b0;
      pair_l     <= '0;
      pair_r     <= '0;
    end else begin
      pair_valid <= 1'b0;
      if (bclk_rise) begin
        lrck_prev <= lrck_sync[1];
        if (lrck_sync[1] != lrck_prev) begin
          bit_cnt <= 5'd0;
        end else if (bit_cnt != 5'd16) begin
          shreg   <= word_next;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            if (!lrck_prev) begin
              left_hold  <= word_next;
              left_valid <= 1'b1;
            end else if (left_valid) begin
              pair_valid <= enable;
              left_valid <= 1'b0;
`ifdef FRAME_CAP_MONO_EN
              pair_l     <= mix_sum[16:1];
              pair_r     <= mix_sum[16:1];
`else
              pair_l     <= left_hold;
              pair_r     <= word_next;
`endif
            end
          end
        end
      end
      if (!enable) left_valid <= 1'b0;
    end
  end

  // ---------------- ping-pong banks ----------------
  logic [15:0]   mem_l [0:DEPTH-1];
  logic [15:0]   mem_r [0:DEPTH-1];
  logic [AW-1:0] wr_ptr;
  logic          wr_bank;
  logic          other_bank;
  logic [1:0]    full;
  logic          en_d;
  logic          free_pulse;
  logic          cbank;
  logic          other_full;

  assign other_bank = ~wr_bank;
  // A bank released by the commit FSM on this very clock counts as free.
  assign other_full = full[other_bank] && !(free_pulse && (cbank == other_bank));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
      en_d    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      en_d <= enable;
      if (enable && !en_d) overrun <= 1'b0;
      if (free_pulse) full[cbank] <= 1'b0;
      if (!enable) begin
        wr_ptr <= '0;
      end else if (pair_valid) begin
        if (wr_ptr == LAST_IDX) begin
          wr_ptr <= '0;
          if (other_full) begin
            overrun <= 1'b1;
          end else begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= other_bank;
          end
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enable && pair_valid) begin
      mem_l[{wr_bank, wr_ptr}] <= pair_l;
      mem_r[{wr_bank, wr_ptr}] <= pair_r;
    end
  end

  // ---------------- commit FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BURST, S_COMMIT} state_t;

  state_t      state, state_nx;
  logic [AW:0] count, count_nx;
  logic        cbank_nx;
  logic        req_valid_nx;
  logic        req_target_nx;
  logic        frame_done_nx;
  logic        rd_en;
  logic [AW:0] rd_addr;

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    cbank_nx      = cbank;
    req_valid_nx  = req_valid;
    req_target_nx = req_target;
    frame_done_nx = 1'b0;
    free_pulse    = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = {cbank, count[AW-1:0]};
    case (state)
      S_IDLE: begin
        if ((full[0] || full[1]) && req_ready) begin
          cbank_nx      = full[0] ? 1'b0 : 1'b1;
          req_valid_nx  = 1'b1;
          req_target_nx = target;
          rd_en         = 1'b1;
          rd_addr       = {cbank_nx, {AW{1'b0}}};
          state_nx      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (busy) begin
          count_nx = {{AW{1'b0}}, 1'b1};
          state_nx = S_BURST;
        end
      end
      S_BURST: begin
        if (count == FULL_CNT) begin
          req_valid_nx = 1'b0;
          state_nx     = S_COMMIT;
        end else begin
          rd_en    = 1'b1;
          count_nx = count + 1'b1;
        end
      end
      S_COMMIT: begin
        if (!busy) begin
          frame_done_nx = 1'b1;
          free_pulse    = 1'b1;
          state_nx      = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      cbank      <= 1'b0;
      req_valid  <= 1'b0;
      req_target <= 1'b0;
      frame_done <= 1'b0;
      data_l     <= '0;
      data_r     <= '0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      cbank      <= cbank_nx;
      req_valid  <= req_valid_nx;
      req_target <= req_target_nx;
      frame_done <= frame_done_nx;
      if (rd_en) begin
        data_l <= mem_l[rd_addr];
        data_r <= mem_r[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_capture.sv
// tb/tb_i2s_frame_capture.sv - scoreboard bench for i2s_frame_capture with a RAM controller model
module tb_i2s_frame_capture;

  localparam int FL = 4;
  localparam int AW = 2;
  localparam int HB = 30;   // half BCLK period
  localparam int SB = 20;   // BCLK periods per LR slot

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk = 1'b0;
  logic        adclrck = 1'b0;
  logic        adcdat = 1'b0;
  logic        enable = 1'b0;
  logic        target = 1'b0;
  logic        req_ready = 1'b1;
  logic        busy = 1'b0;
  logic        req_valid, req_type, req_target, stop, frame_done, overrun;
  logic [15:0] data_l, data_r;

  always #5 clk = ~clk;

  i2s_frame_capture #(.FRAME_LEN(FL), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .adclrck(adclrck), .adcdat(adcdat),
    .enable(enable), .target(target), .req_ready(req_ready), .busy(busy),
    .req_valid(req_valid), .req_type(req_type), .req_target(req_target), .stop(stop),
    .data_l(data_l), .data_r(data_r), .frame_done(frame_done), .overrun(overrun)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] pair_buf[$];
  logic [31:0] exp_q[$];
  logic        exp_tgt_q[$];
  logic [31:0] last_frame [FL];
  int          exp_frames_total = 0;
  bit          hold = 0;
  int          held = 0;
  logic        exp_overrun = 1'b0;

  function automatic logic [31:0] expected_word(input logic [15:0] l, input logic [15:0] r);
`ifdef FRAME_CAP_MONO_EN
    int sl, sr, m;
    sl = $signed(l);
    sr = $signed(r);
    m  = (sl + sr) >>> 1;
    return {m[15:0], m[15:0]};
`else
    return {l, r};
`endif
  endfunction

  task automatic model_add_pair(input logic [15:0] l, input logic [15:0] r);
    pair_buf.push_back(expected_word(l, r));
    if (pair_buf.size() == FL) begin
      if (hold && held > 0) begin
        exp_overrun = 1'b1;
      end else begin
        for (int i = 0; i < FL; i++) begin
          exp_q.push_back(pair_buf[i]);
          last_frame[i] = pair_buf[i];
        end
        exp_tgt_q.push_back(target);
        exp_frames_total++;
        if (hold) held++;
      end
      pair_buf.delete();
    end
  endtask

  // ---------------- I2S source ----------------
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    logic        ok;
    logic [15:0] w;
    ok = enable;
    for (int s = 0; s < 2; s++) begin
      w = (s == 1) ? r : l;
      for (int j = 0; j < SB; j++) begin
        if (j == 0) adclrck = (s == 1);
        adcdat = (j >= 1 && j <= 16) ? w[16-j] : 1'($urandom_range(0, 1));
        if (j == 17) begin
          ok = ok & enable;
          if (s == 1 && ok) model_add_pair(l, r);
        end
        #HB bclk = 1'b1;
        #HB bclk = 1'b0;
      end
    end
  endtask

  // Right slot that only re-establishes LR edge tracking.
  task automatic send_dummy_right();
    for (int j = 0; j < SB; j++) begin
      if (j == 0) adclrck = 1'b1;
      adcdat = 1'($urandom_range(0, 1));
      #HB bclk = 1'b1;
      #HB bclk = 1'b0;
    end
  endtask

  task automatic start_phase(input logic tgt);
    enable = 1'b0;
    target = tgt;
    repeat (10) @(posedge clk);
    @(negedge clk);
    send_dummy_right();
    pair_buf.delete();
    enable = 1'b1;
    exp_overrun = 1'b0;
  endtask

  // ---------------- RAM controller model + burst monitor ----------------
  logic [31:0] ram [0:255];
  int          addr = 0;
  logic [31:0] burst_w[$];
  bit          act_not_ready = 0;
  int          fd_count = 0;

  task automatic check_burst();
    logic [31:0] e;
    logic [31:0] a;
    check("burst_expected", 32'(exp_tgt_q.size() > 0), 32'd1);
    if (exp_tgt_q.size() > 0) begin
      check("burst_len", 32'(burst_w.size()), 32'(FL));
      check("req_target", 32'(req_target), 32'(exp_tgt_q.pop_front()));
      for (int i = 0; i < FL; i++) begin
        e = exp_q.pop_front();
        a = (i < burst_w.size()) ? burst_w[i] : 32'hxxxx_xxxx;
        check($sformatf("word%0d", i), a, e);
      end
    end
    burst_w.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      addr = 0;
      burst_w.delete();
    end else begin
      if (frame_done) fd_count++;
      if (!req_ready && req_valid && !busy) act_not_ready = 1;
      if (!busy) begin
        if (req_valid && req_ready) begin
          busy = 1'b1;
          addr = 0;
        end
      end else if (req_valid && !stop) begin
        ram[addr[7:0]] = {data_l, data_r};
        burst_w.push_back({data_l, data_r});
        addr++;
      end else begin
        busy = 1'b0;
        check_burst();
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_tgt_q.size() != 0 || busy || req_valid) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending_frames", 32'(exp_tgt_q.size()), 32'd0);
    check("overrun", 32'(overrun), 32'(exp_overrun));
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) check(name, 32'(busy), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] base;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_type", 32'(req_type), 32'd1);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data_l", 32'(data_l), 32'd0);
    check("rst_data_r", 32'(data_r), 32'd0);
    check("rst_req_target", 32'(req_target), 32'd0);
    rst_n = 1'b1;

    // fixed pattern, one frame to Rx
    start_phase(1'b0);
    repeat (FL) send_pair(16'h1234, 16'hABCD);
    wait_idle();

    // incrementing stream, three frames
    start_phase(1'($urandom_range(0, 1)));
    base = 16'($urandom);
    for (int n = 0; n < 3 * FL; n++) send_pair(base + 16'(n), ~(base + 16'(n)));
    wait_idle();
    for (int i = 0; i < FL; i++) check($sformatf("ram_addr%0d", i), ram[i], last_frame[i]);

    // downmix corner pairs plus random data
    start_phase(1'($urandom_range(0, 1)));
    send_pair(16'h7FFF, 16'h8001);
    send_pair(16'h8000, 16'h8000);
    for (int n = 0; n < 3 * FL - 2; n++) send_pair(16'($urandom), 16'($urandom));
    wait_idle();

    // req_ready held low for three frame periods
    start_phase(1'($urandom_range(0, 1)));
    hold = 1;
    held = 0;
    req_ready = 1'b0;
    for (int n = 0; n < 3 * FL + 2; n++) send_pair(16'($urandom), 16'($urandom));
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'(exp_overrun));
    check("no_req_while_not_ready", 32'(act_not_ready), 32'd0);
    req_ready = 1'b1;
    hold = 0;
    for (int n = 0; n < FL - 2; n++) send_pair(16'($urandom), 16'($urandom));
    wait_idle();

    // enable dropped two clocks into the burst
    start_phase(1'($urandom_range(0, 1)));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);
    fork
      for (int n = 0; n < 2 * FL; n++) send_pair(16'($urandom), 16'($urandom));
      begin
        wait_busy("busy_timeout_enable");
        repeat (2) @(posedge clk);
        #2 enable = 1'b0;
      end
    join
    wait_idle();

    // reset pulse during the burst
    start_phase(1'b1);
    fork
      repeat (FL) send_pair(16'($urandom), 16'($urandom));
      begin
        wait_busy("busy_timeout_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_valid", 32'(req_valid), 32'd0);
        check("async_rst_data_l", 32'(data_l), 32'd0);
        check("async_rst_req_target", 32'(req_target), 32'd0);
        exp_frames_total -= exp_tgt_q.size();
        exp_q.delete();
        exp_tgt_q.delete();
        pair_buf.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    start_phase(1'b0);
    repeat (FL) send_pair(16'($urandom), 16'($urandom));
    wait_idle();

    check("frame_done_pulses", 32'(fd_count), 32'(exp_frames_total));
    check("expected_words_left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
